// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor, and either keep the difference or restore the shifted remainder.
module div_step #(
   parameter int N = 4
) (
   input  logic [N:0]   rem_in,
   input  logic         bit_in,
   input  logic [N-1:0] divisor,
   output logic [N:0]   rem_out,
   output logic         q_bit
);

   logic [N+1:0] shifted;
   logic [N+1:0] diff;

   always_comb begin
      shifted = {rem_in, bit_in};
      diff    = shifted - {2'b00, divisor};
      // The top bit of diff is the borrow; no borrow means the divisor fit.
      q_bit   = ~diff[N+1];
      rem_out = q_bit ? diff[N:0] : shifted[N:0];
   end

endmodule

// File: rtl/divider.sv
// Multi-cycle unsigned restoring divider: fixed latency of N cycles from the
// accepting edge to a one-cycle ready pulse; results held until the next completion.
module divider #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic         busy,
   output logic         ready,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         div_by_zero
);

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_DIVIDING = 2'd1;
   localparam logic [1:0] ST_DONE     = 2'd2;
   localparam int         CW          = $clog2(N) + 1;
   localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

   typedef enum logic [1:0] {
      IDLE     = ST_IDLE,
      DIVIDING = ST_DIVIDING,
      DONE     = ST_DONE
   } state_t;

   state_t        state_reg, state_next;
   logic [N-1:0]  shift_reg;
   logic [N-1:0]  divisor_reg;
   logic [N:0]    rem_reg;
   logic [CW-1:0] cnt_reg;
   logic [N-1:0]  quotient_reg;
   logic [N-1:0]  remainder_reg;
   logic          dbz_reg;
   logic          ready_reg;

   logic          load, step, finish;
   logic [N:0]    rem_next;
   logic          q_bit;
   logic [N-1:0]  shift_next;

   div_step #(.N(N)) u_step (
      .rem_in  (rem_reg),
      .bit_in  (shift_reg[N-1]),
      .divisor (divisor_reg),
      .rem_out (rem_next),
      .q_bit   (q_bit)
   );

   // Dividend bits leave at the MSB while quotient bits enter at the LSB.
   assign shift_next = {shift_reg[N-2:0], q_bit};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      load       = 1'b0;
      step       = 1'b0;
      finish     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               load       = 1'b1;
               state_next = DIVIDING;
            end
         end
         DIVIDING: begin
            step = 1'b1;
            if (cnt_reg == LAST_STEP) begin
               finish     = 1'b1;
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_reg     <= '0;
         divisor_reg   <= '0;
         rem_reg       <= '0;
         cnt_reg       <= '0;
         quotient_reg  <= '0;
         remainder_reg <= '0;
         dbz_reg       <= 1'b0;
         ready_reg     <= 1'b0;
      end else begin
         ready_reg <= finish;
         if (load) begin
            shift_reg   <= dividend;
            divisor_reg <= divisor;
            rem_reg     <= '0;
            cnt_reg     <= '0;
         end
         if (step) begin
            shift_reg <= shift_next;
            rem_reg   <= rem_next;
            cnt_reg   <= cnt_reg + CW'(1);
         end
         // A zero divisor needs no special path: every trial subtract
         // succeeds, giving all-ones and the dividend as remainder.
         if (finish) begin
            quotient_reg  <= shift_next;
            remainder_reg <= rem_next[N-1:0];
            dbz_reg       <= (divisor_reg == '0);
         end
      end
   end

   assign busy        = (state_reg == DIVIDING);
   assign ready       = ready_reg;
   assign quotient    = quotient_reg;
   assign remainder   = remainder_reg;
   assign div_by_zero = dbz_reg;

endmodule
